// File: rtl/boxcar_avg8.sv
// boxcar_avg8: moving-average controller around an external 32x8 SRL.
// Build option BOXCAR_ROUND_EN: round half up before the avg shift.
module boxcar_avg8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_stb,
  input  logic [7:0]  in_d,
  input  logic [4:0]  len,
  input  logic [2:0]  sh,
  input  logic        clr,
  output logic [7:0]  srl_d,
  output logic        srl_ce,
  output logic [4:0]  srl_a,
  input  logic [7:0]  srl_y,
  output logic        out_stb,
  output logic [12:0] sum,
  output logic [7:0]  avg,
  output logic        filling
);

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic [4:0]          r_len;
  logic [4:0]          r_cnt;
  logic [12:0]         r_sum;
  logic [7:0]          r_avg;
  logic                r_stb;

  logic                w_restart;
  logic                w_acc;
  logic                w_done;
  logic [12:0]         w_sub;
  logic [12:0]         w_sum_nx;
  logic [2:0]          w_sh;
  logic [13:0]         w_bias;
  logic signed [13:0]  w_pre;
  logic signed [13:0]  w_shf;
  logic [7:0]          w_avg_nx;

  assign w_restart = clr | (len != r_len);
  assign w_acc     = in_stb & ~w_restart;
  assign w_done    = (r_state == RUN) | (r_cnt == r_len);

  // SRL contents are stale until the window has been refilled
  assign w_sub    = (r_state == RUN) ?
                    {{5{srl_y[7]}}, srl_y} : 13'd0;
  assign w_sum_nx = r_sum + {{5{in_d[7]}}, in_d} - w_sub;

  assign w_sh = (sh > 3'd5) ? 3'd5 : sh;

`ifdef BOXCAR_ROUND_EN
  assign w_bias = (w_sh == 3'd0) ? 14'd0 :
                  (14'd1 << (w_sh - 3'd1));
`else
  assign w_bias = 14'd0;
`endif

  // Scale and saturate the next sum into the 8-bit average
  always_comb begin
    w_pre = $signed({w_sum_nx[12], w_sum_nx} + w_bias);
    w_shf = w_pre >>> w_sh;
    if (w_shf > 14'sd127)
      w_avg_nx = 8'h7F;
    else if (w_shf < -14'sd128)
      w_avg_nx = 8'h80;
    else
      w_avg_nx = w_shf[7:0];
  end

  // Next-state: restart forces FILL, last fill sample enters RUN
  always_comb begin
    w_state_nx = r_state;
    if (w_restart)
      w_state_nx = FILL;
    else if (w_acc && r_state == FILL && r_cnt == r_len)
      w_state_nx = RUN;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= FILL;
    else
      r_state <= w_state_nx;
  end

  // Length, fill count, running sum and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len <= 5'd0;
      r_cnt <= 5'd0;
      r_sum <= 13'd0;
      r_avg <= 8'd0;
      r_stb <= 1'b0;
    end else if (w_restart) begin
      r_len <= len;
      r_cnt <= 5'd0;
      r_sum <= 13'd0;
      r_avg <= 8'd0;
      r_stb <= 1'b0;
    end else begin
      r_stb <= w_acc & w_done;
      if (w_acc) begin
        r_sum <= w_sum_nx;
        r_avg <= w_avg_nx;
        if (!w_done)
          r_cnt <= r_cnt + 5'd1;
      end
    end
  end

  assign srl_d   = in_d;
  assign srl_ce  = w_acc;
  assign srl_a   = r_len;
  assign out_stb = r_stb;
  assign sum     = r_sum;
  assign avg     = r_avg;
  assign filling = (r_state == FILL);

endmodule

// File: tb/tb_boxcar_avg8.sv
// tb_boxcar_avg8: directed vectors, queue scoreboard.
// Includes a behavioural 32x8 SRL delay line.
module tb_boxcar_avg8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_stb;
  logic [7:0]  in_d;
  logic [4:0]  len;
  logic [2:0]  sh;
  logic        clr;
  logic [7:0]  srl_d;
  logic        srl_ce;
  logic [4:0]  srl_a;
  logic [7:0]  srl_y;
  logic        out_stb;
  logic [12:0] sum;
  logic [7:0]  avg;
  logic        filling;

  typedef struct {
    int s;
    int a;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;

`ifdef BOXCAR_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  boxcar_avg8 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_stb  (in_stb),
    .in_d    (in_d),
    .len     (len),
    .sh      (sh),
    .clr     (clr),
    .srl_d   (srl_d),
    .srl_ce  (srl_ce),
    .srl_a   (srl_a),
    .srl_y   (srl_y),
    .out_stb (out_stb),
    .sum     (sum),
    .avg     (avg),
    .filling (filling)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [32];

  initial begin
    for (int i = 0; i < 32; i++)
      mem[i] = 8'h55;
  end

  always @(posedge clk) begin
    if (srl_ce) begin
      mem[0] <= srl_d;
      for (int i = 1; i < 32; i++)
        mem[i] <= mem[i-1];
    end
  end

  assign srl_y = mem[srl_a];

  task automatic chk(input string nm,
                     input int act,
                     input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d",
               nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_stb) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_stb sum=%0d",
                 $signed(sum));
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sum", int'($signed(sum)), e.s);
        chk("avg", int'($signed(avg)), e.a);
      end
    end
  end

  function automatic int eavg(input int s,
                              input int k);
    int r;
    if (RND && k > 0)
      s = s + (1 << (k - 1));
    r = s >>> k;
    if (r > 127)
      r = 127;
    if (r < -128)
      r = -128;
    return r;
  endfunction

  task automatic send(input int d,
                      input bit v,
                      input int es,
                      input int ea);
    in_stb = 1'b1;
    in_d   = d[7:0];
    if (v)
      q.push_back('{es, ea});
    @(posedge clk);
    #1;
    in_stb = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    in_stb = 1'b0;
    in_d   = 8'd0;
    len    = 5'd3;
    sh     = 3'd2;
    clr    = 1'b0;
    #1;
    chk("rst_stb", int'(out_stb), 0);
    chk("rst_sum", int'(sum), 0);
    chk("rst_fill", int'(filling), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    for (int i = 1; i <= 3; i++)
      send(10, 1'b0, 0, 0);
    chk("fill_hi", int'(filling), 1);
    send(10, 1'b1, 40, 10);
    chk("fill_lo", int'(filling), 0);
    for (int i = 5; i <= 8; i++)
      send(10, 1'b1, 40, 10);
    idle(1);
    chk("drain2", q.size(), 0);

    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    for (int i = 1; i <= 3; i++)
      send(0, 1'b0, 0, 0);
    send(0, 1'b1, 0, 0);
    send(100, 1'b1, 100, 25);
    send(100, 1'b1, 200, 50);
    send(100, 1'b1, 300, 75);
    send(100, 1'b1, 400, 100);
    len = 5'd1;
    idle(1);
    send(100, 1'b0, 0, 0);
    send(100, 1'b1, 200, 50);
    idle(1);
    chk("drain3", q.size(), 0);

    rst_n = 1'b0;
    #1;
    chk("mid_stb", int'(out_stb), 0);
    chk("mid_sum", int'(sum), 0);
    chk("mid_avg", int'(avg), 0);
    chk("mid_fill", int'(filling), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    send(7, 1'b0, 0, 0);
    send(7, 1'b1, 14, RND ? 4 : 3);
    idle(1);
    chk("drain1", q.size(), 0);

    len = 5'd31;
    sh  = 3'd5;
    idle(1);
    for (int i = 1; i <= 31; i++)
      send(-128, 1'b0, 0, 0);
    send(-128, 1'b1, -4096, -128);
    for (int k = 1; k <= 32; k++)
      send(127, 1'b1, -4096 + 255 * k,
           eavg(-4096 + 255 * k, 5));
    idle(1);
    chk("drain4", q.size(), 0);
    chk("run4", int'(filling), 0);

    clr    = 1'b1;
    in_stb = 1'b1;
    in_d   = 8'd5;
    #1;
    chk("clr_ce", int'(srl_ce), 0);
    @(posedge clk);
    #1;
    clr    = 1'b0;
    in_stb = 1'b0;
    chk("clr_stb", int'(out_stb), 0);
    chk("clr_fill", int'(filling), 1);
    chk("clr_sum", int'(sum), 0);
    idle(2);

    len = 5'd0;
    sh  = 3'd1;
    idle(1);
    send(-3, 1'b1, -3, RND ? -1 : -2);
    send(127, 1'b1, 127, RND ? 64 : 63);
    sh = 3'd7;
    send(127, 1'b1, 127, RND ? 4 : 3);
    send(-100, 1'b1, -100, RND ? -3 : -4);
    idle(2);
    chk("drain6", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
